input_handshake_controller: RTL and testbench
=============================================

Name: input_handshake_controller

Overview:
Responder side of the control unit's input-stall protocol. While the control unit asserts isInsert (an in, ckhd, ckim or ckdm instruction with input enabled), this block holds the processor stalled. It waits for the operator to set the switches and press and release the confirm button, captures the switch value, and then releases the stall with a one-cycle pulse. It sits between the board switches/button and the datapath's input-data mux (regWrtSelect=2'b10) and the PC/clock-enable logic.

Parameters:
DATA_W, 16, width of the switch bus
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a button level change
BTN_ACTIVE_LOW, 1, 1 means the raw button reads 0 when pressed
SIGN_EXT, 0, 1 means sign-extend the switch value to 32 bits; 0 means zero-extend

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
isInsert  input  1  stall request from the control unit, level, combinational from the current instruction
switches  input  DATA_W  raw board switches, sampled only at capture
confirmBtn  input  1  raw, asynchronous, bouncing confirm button
inputData  output  32  captured switch value, extended per SIGN_EXT
stall  output  1  high while the processor must hold the PC and suppress writes
release  output  1  one-cycle pulse; the processor completes the stalled instruction on this cycle
waitingLed  output  1  operator indicator, equal to stall
state  output  3  current FSM state, for the LCD/debug

Behaviour:
- Reset (rst=0, async): state=IDLE; inputData=0; stall=0; release=0; debounce counter=0; debounced button=released; synchronizer flops=released level.
- confirmBtn passes through a 2-FF synchronizer and is inverted if BTN_ACTIVE_LOW, giving btnS (1=pressed).
- Debouncer: if btnS differs from btnDb, the counter increments; otherwise the counter clears. When the counter reaches DEBOUNCE_CYCLES-1 while btnS still differs, btnDb takes btnS and the counter clears. The counter saturates and never wraps.
- Encoding: IDLE=0, WAIT_PRESS=1, WAIT_RELEASE=2, DONE=3, HOLDOFF=4. Codes 5-7 go to IDLE on the next cycle.
- IDLE:
  - isInsert=1 and btnDb=0 -> WAIT_PRESS.
  - isInsert=1 and btnDb=1 (button already held) -> WAIT_RELEASE_PRE. This state is encoded by WAIT_PRESS with an internal flag set; it waits for btnDb=0 before arming.
- WAIT_PRESS: on a btnDb rising edge (0->1), capture switches into inputData in that same cycle (extended per SIGN_EXT) -> WAIT_RELEASE.
- WAIT_RELEASE: on a btnDb falling edge -> DONE.
- DONE: release=1 for exactly this cycle -> HOLDOFF.
- HOLDOFF: isInsert is ignored for one cycle so the PC can advance -> IDLE.
- stall=1 in WAIT_PRESS, WAIT_RELEASE and DONE; stall=0 in IDLE and HOLDOFF. Latency from isInsert rising to stall rising is 1 cycle (registered).
- Abort: if isInsert falls in WAIT_PRESS or WAIT_RELEASE (for example a BIOS reset), go to IDLE next cycle. No release pulse is issued and inputData keeps its prior value.
- inputData changes only at capture and reset; it holds across later instructions.
- Back-to-back inputs: if isInsert is still 1 in IDLE after HOLDOFF, a new handshake starts. A single press never satisfies two inputs, because every capture needs a fresh 0->1 edge of btnDb.
- Bounce shorter than DEBOUNCE_CYCLES has no effect on state.

Test Plan (DEBOUNCE_CYCLES=4, DATA_W=16):
- Basic in:
  - Stimulus: isInsert=1; switches=16'h00A5; clean press for 10 cycles, then release.
  - Required: stall rises 1 cycle after isInsert; inputData=32'h000000A5 from 4+2 cycles after the press; exactly one release pulse after the debounced release; stall=0 afterwards.
- Sign extension:
  - Stimulus: SIGN_EXT=1, switches=16'h8001.
  - Required: inputData=32'hFFFF8001. With SIGN_EXT=0 the same stimulus gives 32'h00008001.
- Bounce:
  - Stimulus: press toggling every 2 cycles for 12 cycles, then stable pressed.
  - Required: no capture during the bounce; exactly one capture, 4 stable cycles after settling.
- Abort:
  - Stimulus: drop isInsert while in WAIT_RELEASE.
  - Required: IDLE next cycle, release never pulses, inputData unchanged.
- Held button and back-to-back:
  - Stimulus: button held when isInsert rises.
  - Required: no capture until release followed by a new press. Two consecutive in instructions need two presses; values 3 and 7 are captured in order with two release pulses.
- Async reset mid-handshake:
  - Stimulus: rst=0 asserted in WAIT_PRESS, off a clock edge.
  - Required: immediately state=0, stall=0, inputData=0; after rst=1 with isInsert=1, stall re-asserts 1 cycle later.

Source files
------------

// File: rtl/input_handshake_controller.sv
// Operator input handshake: stalls the core on isInsert until a debounced
// press/release of the confirm button, capturing the switches on the press.
module input_handshake_controller #(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int SIGN_EXT        = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isInsert,
  input  logic [DATA_W-1:0] switches,
  input  logic              confirmBtn,
  output logic [31:0]       inputData,
  output logic              stall,
  output logic              release_pulse,
  output logic              waitingLed,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_PRESS   = 3'd1,
    WAIT_RELEASE = 3'd2,
    DONE         = 3'd3,
    HOLDOFF      = 3'd4
  } st_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic RAW_IDLE = (BTN_ACTIVE_LOW != 0);

  logic          sync1, sync2;
  logic          btn_s, btn_db;
  logic [CW-1:0] cnt;
  logic          db_flip, db_rise, db_fall;

  st_t         st_q, st_d;
  logic        pre_q, pre_d;
  logic [31:0] data_q, data_d;
  logic [31:0] sw_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= confirmBtn;
      sync2 <= sync1;
    end
  end

  assign btn_s   = sync2 ^ RAW_IDLE;
  assign db_flip = (btn_s != btn_db) && (cnt == LAST);
  assign db_rise = db_flip & btn_s;
  assign db_fall = db_flip & ~btn_s;

  // Counter only grows while the sample differs and clears on the flip,
  // so it never passes LAST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      cnt <= '0;
    end else if (db_flip) begin
      cnt    <= '0;
      btn_db <= btn_s;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sw_ext = (SIGN_EXT != 0) ? 32'($signed(switches))
                                  : 32'(switches);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      pre_q  <= 1'b0;
      data_q <= '0;
    end else begin
      st_q   <= st_d;
      pre_q  <= pre_d;
      data_q <= data_d;
    end
  end

  // pre_q marks a button already held at request time; it must be
  // seen released before a press can be accepted.
  always_comb begin
    st_d   = st_q;
    pre_d  = pre_q;
    data_d = data_q;
    case (st_q)
      IDLE: begin
        if (isInsert) begin
          st_d  = WAIT_PRESS;
          pre_d = btn_db;
        end
      end
      WAIT_PRESS: begin
        if (!isInsert) begin
          st_d = IDLE;
        end else if (pre_q) begin
          if (!btn_db) pre_d = 1'b0;
        end else if (db_rise) begin
          data_d = sw_ext;
          st_d   = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!isInsert) st_d = IDLE;
        else if (db_fall) st_d = DONE;
      end
      DONE:    st_d = HOLDOFF;
      HOLDOFF: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  assign state         = st_q;
  assign inputData     = data_q;
  assign stall         = (st_q == WAIT_PRESS) ||
                         (st_q == WAIT_RELEASE) ||
                         (st_q == DONE);
  assign release_pulse = (st_q == DONE);
  assign waitingLed    = stall;

endmodule

// File: tb/tb_input_handshake_controller.sv
// Bench for input_handshake_controller: vector table, reset sequence,
// and random stimulus against a behavioural model.
module tb_input_handshake_controller;
  localparam int DW = 16;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          isInsert = 1'b0;
  logic [DW-1:0] switches = '0;
  logic          press = 1'b0;
  logic          confirmBtn;

  logic [31:0] z_data, s_data;
  logic        z_stall, s_stall, z_rel, s_rel, z_led, s_led;
  logic [2:0]  z_state, s_state;

  assign confirmBtn = ~press;
  always #5 clk = ~clk;

  input_handshake_controller #(
    .DATA_W(DW), .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW(1), .SIGN_EXT(0)
  ) dut_z (
    .clk(clk), .rst(rst), .isInsert(isInsert),
    .switches(switches), .confirmBtn(confirmBtn),
    .inputData(z_data), .stall(z_stall),
    .release_pulse(z_rel), .waitingLed(z_led),
    .state(z_state)
  );

  input_handshake_controller #(
    .DATA_W(DW), .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW(1), .SIGN_EXT(1)
  ) dut_s (
    .clk(clk), .rst(rst), .isInsert(isInsert),
    .switches(switches), .confirmBtn(confirmBtn),
    .inputData(s_data), .stall(s_stall),
    .release_pulse(s_rel), .waitingLed(s_led),
    .state(s_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: the button is seen two clocks late, a level is
  // accepted after DB consecutive differing samples, then the handshake.
  bit          pipe[$];
  bit          m_db;
  int          m_run;
  int          m_ph;
  bit          m_pre;
  logic [31:0] m_d, m_sd;

  task automatic model_reset();
    pipe  = {1'b0, 1'b0};
    m_db  = 0;
    m_run = 0;
    m_ph  = 0;
    m_pre = 0;
    m_d   = 0;
    m_sd  = 0;
  endtask

  task automatic model_step();
    bit bs, db0, rise, fall;
    bs   = pipe.pop_front();
    pipe.push_back(press);
    db0  = m_db;
    rise = 0;
    fall = 0;
    if (bs != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = bs;
        m_run = 0;
        rise  = bs;
        fall  = !bs;
      end
    end else begin
      m_run = 0;
    end
    case (m_ph)
      0: if (isInsert) begin m_ph = 1; m_pre = db0; end
      1: begin
        if (!isInsert) m_ph = 0;
        else if (m_pre) begin
          if (!db0) m_pre = 0;
        end else if (rise) begin
          m_d  = 32'(switches);
          m_sd = 32'($signed(switches));
          m_ph = 2;
        end
      end
      2: if (!isInsert) m_ph = 0; else if (fall) m_ph = 3;
      3: m_ph = 4;
      default: m_ph = 0;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    bit          ins;
    bit          prs;
    logic [15:0] sw;
    int          n;
    logic [2:0]  st;
    bit          stl;
    bit          rel;
    logic [31:0] d;
    logic [31:0] sd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(bit ins, bit prs, logic [15:0] sw, int n,
                             logic [2:0] st, bit stl, bit rel,
                             logic [31:0] d, logic [31:0] sd);
    vec_t r;
    r.ins = ins; r.prs = prs; r.sw = sw; r.n = n;
    r.st = st; r.stl = stl; r.rel = rel; r.d = d; r.sd = sd;
    return r;
  endfunction

  initial begin
    // basic capture of 00A5
    tv.push_back(v(0,0,16'h0000,1,0,0,0,32'h0,32'h0));
    tv.push_back(v(1,0,16'h00A5,1,1,1,0,32'h0,32'h0));
    tv.push_back(v(1,1,16'h00A5,5,1,1,0,32'h0,32'h0));
    tv.push_back(v(1,1,16'h00A5,1,2,1,0,32'hA5,32'hA5));
    tv.push_back(v(1,1,16'h00A5,4,2,1,0,32'hA5,32'hA5));
    tv.push_back(v(1,0,16'h00A5,5,2,1,0,32'hA5,32'hA5));
    tv.push_back(v(1,0,16'h00A5,1,3,1,1,32'hA5,32'hA5));
    tv.push_back(v(1,0,16'h00A5,1,4,0,0,32'hA5,32'hA5));
    tv.push_back(v(0,0,16'h00A5,1,0,0,0,32'hA5,32'hA5));
    // 8001 capture, extension, then abort in WAIT_RELEASE
    tv.push_back(v(1,0,16'h8001,1,1,1,0,32'hA5,32'hA5));
    tv.push_back(v(1,1,16'h8001,6,2,1,0,32'h8001,32'hFFFF8001));
    tv.push_back(v(0,1,16'h8001,1,0,0,0,32'h8001,32'hFFFF8001));
    tv.push_back(v(0,0,16'h8001,8,0,0,0,32'h8001,32'hFFFF8001));
    // bounce every 2 cycles, then a settled press
    tv.push_back(v(1,0,16'h0042,1,1,1,0,32'h8001,32'hFFFF8001));
    for (int k = 0; k < 6; k++)
      tv.push_back(v(1,(k%2==0),16'h0042,2,1,1,0,
                     32'h8001,32'hFFFF8001));
    tv.push_back(v(1,1,16'h0042,5,1,1,0,32'h8001,32'hFFFF8001));
    tv.push_back(v(1,1,16'h0042,1,2,1,0,32'h42,32'h42));
    tv.push_back(v(1,0,16'h0042,5,2,1,0,32'h42,32'h42));
    tv.push_back(v(1,0,16'h0042,1,3,1,1,32'h42,32'h42));
    tv.push_back(v(0,0,16'h0042,1,4,0,0,32'h42,32'h42));
    tv.push_back(v(0,0,16'h0042,1,0,0,0,32'h42,32'h42));
    // held button at request, then back-to-back 3 and 7
    tv.push_back(v(0,1,16'h0003,8,0,0,0,32'h42,32'h42));
    tv.push_back(v(1,1,16'h0003,1,1,1,0,32'h42,32'h42));
    tv.push_back(v(1,1,16'h0003,8,1,1,0,32'h42,32'h42));
    tv.push_back(v(1,0,16'h0003,6,1,1,0,32'h42,32'h42));
    tv.push_back(v(1,1,16'h0003,5,1,1,0,32'h42,32'h42));
    tv.push_back(v(1,1,16'h0003,1,2,1,0,32'h3,32'h3));
    tv.push_back(v(1,0,16'h0003,5,2,1,0,32'h3,32'h3));
    tv.push_back(v(1,0,16'h0003,1,3,1,1,32'h3,32'h3));
    tv.push_back(v(1,0,16'h0007,1,4,0,0,32'h3,32'h3));
    tv.push_back(v(1,0,16'h0007,1,0,0,0,32'h3,32'h3));
    tv.push_back(v(1,0,16'h0007,1,1,1,0,32'h3,32'h3));
    tv.push_back(v(1,1,16'h0007,6,2,1,0,32'h7,32'h7));
    tv.push_back(v(1,0,16'h0007,6,3,1,1,32'h7,32'h7));
    tv.push_back(v(0,0,16'h0007,1,4,0,0,32'h7,32'h7));
    tv.push_back(v(0,0,16'h0007,1,0,0,0,32'h7,32'h7));

    model_reset();
    #2;
    chk("reset_state", 32'(z_state), 32'd0);
    chk("reset_stall", 32'(z_stall), 32'd0);
    chk("reset_data", z_data, 32'h0);
    #10 rst = 1'b1;

    foreach (tv[i]) begin
      isInsert = tv[i].ins;
      press    = tv[i].prs;
      switches = tv[i].sw;
      repeat (tv[i].n) tick();
      chk($sformatf("v%0d_state", i), 32'(z_state), 32'(tv[i].st));
      chk($sformatf("v%0d_stall", i), 32'(z_stall), 32'(tv[i].stl));
      chk($sformatf("v%0d_led", i), 32'(z_led), 32'(tv[i].stl));
      chk($sformatf("v%0d_rel", i), 32'(z_rel), 32'(tv[i].rel));
      chk($sformatf("v%0d_data", i), z_data, tv[i].d);
      chk($sformatf("v%0d_sdata", i), s_data, tv[i].sd);
    end

    // async reset while in WAIT_PRESS, asserted off the clock edge
    isInsert = 1'b1;
    press    = 1'b0;
    tick();
    chk("pre_rst_state", 32'(z_state), 32'd1);
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("arst_state", 32'(z_state), 32'd0);
    chk("arst_stall", 32'(z_stall), 32'd0);
    chk("arst_data", z_data, 32'h0);
    chk("arst_sdata", s_data, 32'h0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_stall", 32'(z_stall), 32'd1);

    for (int seg = 0; seg < 70; seg++) begin
      isInsert = ($urandom_range(0, 3) != 0);
      press    = $urandom_range(0, 1);
      switches = 16'($urandom);
      for (int c = 0; c < int'($urandom_range(1, 12)); c++) begin
        tick();
        chk("rnd_state", 32'(z_state), 32'(m_ph));
        chk("rnd_stall", 32'(z_stall), 32'(m_ph >= 1 && m_ph <= 3));
        chk("rnd_rel", 32'(z_rel), 32'(m_ph == 3));
        chk("rnd_data", z_data, m_d);
        chk("rnd_sdata", s_data, m_sd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
